// File: rtl/stop_watch_pkg.sv
// Shared constants and types for the stopwatch time-base counter.
// Digit limits, display-mode encodings and the display-word helper.
package stop_watch_pkg;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    localparam logic DISP_SEC_CS  = 1'b0;
    localparam logic DISP_MIN_SEC = 1'b1;

    localparam logic [3:0] DP_DEFAULT = 4'b0100;

    typedef struct packed {
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [3:0] s_tens;
        logic [3:0] s_ones;
        logic [3:0] cs_tens;
        logic [3:0] cs_ones;
    } digits_t;

    // Picks the four digits shown by the scan driver for a given mode.
    function automatic logic [15:0] disp_word(input digits_t d, input logic mode);
        if (mode == DISP_MIN_SEC)
            return {d.m_tens, d.m_ones, d.s_tens, d.s_ones};
        else
            return {d.s_tens, d.s_ones, d.cs_tens, d.cs_ones};
    endfunction

endpackage

// File: rtl/stop_watch_cnt_bcd_digit.sv
// Single BCD digit counter: counts 0..MAX on inc, wraps to 0 with carry.
// clr has priority over inc.
module bcd_digit_cnt
    import stop_watch_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = inc && (q == MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= carry ? 4'd0 : q + 4'd1;
    end

endmodule

// File: rtl/stop_watch_cnt.sv
// Stopwatch time base: counts 100 Hz ticks as MM:SS.cc in BCD and drives
// a registered 4-digit display word selected by disp_mode.
module stop_watch_cnt
    import stop_watch_pkg::*;
#(
    parameter int MIN_MAX      = 59,
    parameter int TICK_PER_SEC = 100
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        pls_100hz,
    input  logic        cnt_en,
    input  logic        clr_plso,
    input  logic        disp_mode,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_dp,
    output logic        sec_pls,
    output logic        ovf
);

    localparam logic [3:0] MM_TENS = 4'(MIN_MAX / 10);
    localparam logic [3:0] MM_ONES = 4'(MIN_MAX % 10);

    // Two BCD centisecond digits only make sense with a 100 Hz time base.
    if (TICK_PER_SEC != 100 || MIN_MAX < 9 || MIN_MAX > 99) begin : g_param_check
        $error("stop_watch_cnt: unsupported TICK_PER_SEC or MIN_MAX");
    end

    logic p0, p1;
    logic tick, clr_tick, inc_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0 <= 1'b0;
            p1 <= 1'b0;
        end else begin
            p0 <= pls_100hz;
            p1 <= p0;
        end
    end

    assign tick     = p0 & ~p1;
    assign clr_tick = tick & clr_plso;
    assign inc_tick = tick & ~clr_plso & cnt_en;

    logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
    logic       c_cs_ones, c_cs_tens, c_s_ones, c_s_tens, c_m_ones;
    logic       min_at_max, wrap;

    assign min_at_max = (m_tens == MM_TENS) && (m_ones == MM_ONES);
    assign wrap       = c_s_tens && min_at_max;

    bcd_digit_cnt #(.MAX(BCD_MAX)) u_cs_ones (
        .clk(clk), .rst(rst), .inc(inc_tick), .clr(clr_tick),
        .q(cs_ones), .carry(c_cs_ones)
    );

    bcd_digit_cnt #(.MAX(BCD_MAX)) u_cs_tens (
        .clk(clk), .rst(rst), .inc(c_cs_ones), .clr(clr_tick),
        .q(cs_tens), .carry(c_cs_tens)
    );

    bcd_digit_cnt #(.MAX(BCD_MAX)) u_s_ones (
        .clk(clk), .rst(rst), .inc(c_cs_tens), .clr(clr_tick),
        .q(s_ones), .carry(c_s_ones)
    );

    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_s_tens (
        .clk(clk), .rst(rst), .inc(c_s_ones), .clr(clr_tick),
        .q(s_tens), .carry(c_s_tens)
    );

    // Minute ones also clear on the MIN_MAX wrap, which may not fall on a 9.
    bcd_digit_cnt #(.MAX(BCD_MAX)) u_m_ones (
        .clk(clk), .rst(rst), .inc(c_s_tens), .clr(clr_tick | wrap),
        .q(m_ones), .carry(c_m_ones)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            m_tens <= '0;
        else if (clr_tick || wrap)
            m_tens <= '0;
        else if (c_m_ones)
            m_tens <= m_tens + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_pls <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            sec_pls <= inc_tick & c_cs_tens;
            if (clr_tick)
                ovf <= 1'b0;
            else if (wrap)
                ovf <= 1'b1;
        end
    end

    digits_t digits;

    assign digits = '{m_tens: m_tens, m_ones: m_ones, s_tens: s_tens,
                      s_ones: s_ones, cs_tens: cs_tens, cs_ones: cs_ones};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_bcd <= '0;
            disp_dp  <= DP_DEFAULT;
        end else begin
            disp_bcd <= disp_word(digits, disp_mode);
            disp_dp  <= DP_DEFAULT;
        end
    end

endmodule

// File: tb/tb_stop_watch_cnt.sv
// Directed bench for stop_watch_cnt: table of count segments with
// hand-computed display values, plus wrap, mode-latency and async-reset cases.
module tb_stop_watch_cnt;

    logic        rst;
    logic        clk;
    logic        pls_100hz;
    logic        cnt_en;
    logic        clr_plso;
    logic        disp_mode;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_dp;
    logic        sec_pls;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;
    int sec_cnt  = 0;

    stop_watch_cnt #(.MIN_MAX(59), .TICK_PER_SEC(100)) dut (
        .rst(rst),
        .clk(clk),
        .pls_100hz(pls_100hz),
        .cnt_en(cnt_en),
        .clr_plso(clr_plso),
        .disp_mode(disp_mode),
        .disp_bcd(disp_bcd),
        .disp_dp(disp_dp),
        .sec_pls(sec_pls),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) begin
        if (sec_pls)
            sec_cnt <= sec_cnt + 1;
    end

    typedef struct {
        int          n;
        logic        en;
        logic        clr;
        logic        mode;
        logic [15:0] bcd;
        logic        ovf;
        int          sec;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // One 100 Hz edge, compressed to two clocks per period.
    task automatic do_tick();
        pls_100hz = 1'b1;
        @(negedge clk);
        pls_100hz = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    int sec0;

    initial begin
        vecs[0]  = '{0,    1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
        vecs[1]  = '{100,  1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1};
        vecs[2]  = '{5900, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 59};
        vecs[3]  = '{0,    1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 0};
        vecs[4]  = '{1,    1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 0};
        vecs[5]  = '{0,    1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 0};
        vecs[6]  = '{1,    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0};
        vecs[7]  = '{1234, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 12};
        vecs[8]  = '{50,   1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 0};
        vecs[9]  = '{3333, 1'b1, 1'b0, 1'b0, 16'h4567, 1'b0, 33};
        vecs[10] = '{1,    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0};
        vecs[11] = '{1,    1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
        vecs[12] = '{1,    1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 0};

        rst       = 1'b0;
        pls_100hz = 1'b0;
        cnt_en    = 1'b0;
        clr_plso  = 1'b0;
        disp_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            cnt_en    = vecs[i].en;
            clr_plso  = vecs[i].clr;
            disp_mode = vecs[i].mode;
            sec0      = sec_cnt;
            for (int k = 0; k < vecs[i].n; k++)
                do_tick();
            settle();
            check("vec_bcd", i, 32'(disp_bcd), 32'(vecs[i].bcd));
            check("vec_dp",  i, 32'(disp_dp),  32'h4);
            check("vec_ovf", i, 32'(ovf),      32'(vecs[i].ovf));
            check("vec_sec", i, 32'(sec_cnt - sec0), 32'(vecs[i].sec));
        end

        // Display mux latency: exactly one clock after disp_mode changes (state 00:00.01).
        cnt_en    = 1'b0;
        disp_mode = 1'b1;
        @(negedge clk);
        check("mode_lat_mm", 0, 32'(disp_bcd), 32'h0000);
        disp_mode = 1'b0;
        @(negedge clk);
        check("mode_lat_ss", 0, 32'(disp_bcd), 32'h0001);

        // Wrap: preload 59:59.98 into the digit registers, then count across.
        force dut.u_cs_ones.q = 4'd8;
        force dut.u_cs_tens.q = 4'd9;
        force dut.u_s_ones.q  = 4'd9;
        force dut.u_s_tens.q  = 4'd5;
        force dut.u_m_ones.q  = 4'd9;
        force dut.m_tens      = 4'd5;
        #1;
        release dut.u_cs_ones.q;
        release dut.u_cs_tens.q;
        release dut.u_s_ones.q;
        release dut.u_s_tens.q;
        release dut.u_m_ones.q;
        release dut.m_tens;
        @(negedge clk);
        cnt_en = 1'b1;
        sec0   = sec_cnt;
        do_tick();
        settle();
        check("pre_wrap_ss", 0, 32'(disp_bcd), 32'h5999);
        check("pre_wrap_ovf", 0, 32'(ovf), 32'h0);
        disp_mode = 1'b1;
        @(negedge clk);
        check("pre_wrap_mm", 0, 32'(disp_bcd), 32'h5959);
        disp_mode = 1'b0;
        do_tick();
        settle();
        check("wrap_bcd", 0, 32'(disp_bcd), 32'h0000);
        check("wrap_ovf", 0, 32'(ovf), 32'h1);
        check("wrap_sec", 0, 32'(sec_cnt - sec0), 32'h1);
        disp_mode = 1'b1;
        @(negedge clk);
        check("wrap_mm", 0, 32'(disp_bcd), 32'h0000);
        disp_mode = 1'b0;
        do_tick();
        settle();
        check("post_wrap_bcd", 0, 32'(disp_bcd), 32'h0001);
        check("ovf_sticky", 0, 32'(ovf), 32'h1);
        clr_plso = 1'b1;
        do_tick();
        clr_plso = 1'b0;
        settle();
        check("ovf_clr", 0, 32'(ovf), 32'h0);
        check("ovf_clr_bcd", 0, 32'(disp_bcd), 32'h0000);

        // Asynchronous reset between edges at 00:07.50.
        cnt_en = 1'b1;
        for (int k = 0; k < 750; k++)
            do_tick();
        settle();
        check("pre_rst_bcd", 0, 32'(disp_bcd), 32'h0750);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_bcd", 0, 32'(disp_bcd), 32'h0000);
        check("arst_dp",  0, 32'(disp_dp),  32'h4);
        check("arst_ovf", 0, 32'(ovf),      32'h0);
        check("arst_sec", 0, 32'(sec_pls),  32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_tick();
        settle();
        check("post_rst_tick", 0, 32'(disp_bcd), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
